alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle shift-add multiply sequencer that drives the shared 32-bit ALU. It computes the low 32 bits of a 32x32 product by issuing ADD operations to the ALU, one per cycle. It sits beside the ALU in the execute stage and owns the ALU's inputs while a multiply is in progress. The result is the same for signed and unsigned operands because only the low word is produced.

## Interface

Parameters:
- EARLY_EXIT, default 1: when 1, the sequence stops once no multiplier bits remain; when 0, it always runs 32 steps.
- ADD_CODE, default 6'b100000: ALU function code for ADD.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low. This is the only clock domain.
- start  in  1  request pulse; sampled only in IDLE.
- op_a  in  32  multiplicand; sampled with an accepted start.
- op_b  in  32  multiplier; sampled with an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse while in DONE.
- result  out  32  product low word; registered, holds until the next DONE.
- alu_dataA  out  32  to ALU dataA.
- alu_dataB  out  32  to ALU dataB.
- alu_Signal  out  6  to ALU Signal.
- alu_dataOut  in  32  from ALU dataOut; combinational ALU result.

## Operation

- Internal registers:
  - state: IDLE, RUN or DONE.
  - mcand[31:0], mplier[31:0], acc[31:0].
  - cnt[4:0].
  - result[31:0].
- IDLE:
  - Drives alu_dataA=0, alu_dataB=0, alu_Signal=ADD_CODE.
  - On start=1: load mcand=op_a, mplier=op_b, acc=0, cnt=0, then go to RUN.
- RUN, each cycle:
  - Drives alu_dataA=acc, alu_dataB=(mplier[0] ? mcand : 0), alu_Signal=ADD_CODE.
  - On the clock edge: acc<=alu_dataOut, mcand<=mcand<<1 (zero fill), mplier<=mplier>>1 (logical shift), cnt<=cnt+1.
- Exit from RUN to DONE, on the same edge:
  - when cnt==31, or
  - when EARLY_EXIT=1 and mplier[31:1]==0.
  - On that edge, result<=alu_dataOut.
- DONE:
  - Lasts exactly one cycle with done=1, then returns to IDLE.
  - ALU drive is the same as in IDLE.
- start is ignored in RUN and DONE; there is no queueing.
- All sums are modulo 2^32. The ALU carry is unused and overflow is discarded.
- result changes only on the RUN to DONE edge and on reset.

## Timing

- Reset (asynchronous assert, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, result=0.
  - alu_dataA=0, alu_dataB=0, alu_Signal=ADD_CODE.
  - All internal registers = 0.
- Reset mid-RUN: the operation is aborted immediately and no done pulse is emitted.
- Cycle numbering: start is accepted at the edge ending cycle 0.
  - RUN occupies cycles 1..N.
  - done=1 in cycle N+1.
  - The next start is accepted at the earliest in cycle N+2.
- N:
  - EARLY_EXIT=0: N=32.
  - EARLY_EXIT=1: N = 1 + (index of the highest set bit of op_b), and N=1 when op_b==0.
- busy=1 exactly in cycles 1..N. busy and done are never high together.
- result is valid from cycle N+1 onward until the next DONE.
- The ALU is combinational: alu_dataOut is consumed in the same cycle it is driven.

## Test plan

- 7 × 6, EARLY_EXIT=1 → result=0x0000002A; busy in cycles 1..3, done in cycle 4.
- 0xFFFFFFFF × 0xFFFFFFFF → result=0x00000001; N=32, done in cycle 33, wrap-around discarded.
- 0xFFFFFFFD (-3) × 5 → result=0xFFFFFFF1; done in cycle 4. 0x1234 × 0 → result=0, done in cycle 2.
- EARLY_EXIT=0, 7 × 6 → result=0x2A, done in cycle 33. On every RUN cycle where the shifted mplier[0]=0, alu_dataB=0 and alu_Signal=6'b100000.
- Start 3 × 0x80000000 (N=32); pulse start with 5 × 5 in cycle 10 → ignored, result=0x80000000 at cycle 33. Back-to-back 2 × 2 started in cycle 34 → result=4.
- Start 9 × 9, drop rst_n in cycle 2 → busy=0, result=0, state IDLE asynchronously, no done. After rst_n rises, 9 × 9 → result=0x51.

Source files
------------

// File: rtl/alu_mul_seq.sv
// alu_mul_seq
// Shift-add multiply sequencer that borrows the shared 32-bit ALU to form the
// low 32 bits of a 32x32 product, one ADD per cycle. Because only the low word
// is kept, the result is the same for signed and unsigned operands.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request pulse, honoured only while idle
//   op_a, op_b   multiplicand / multiplier, captured with an accepted start
//   busy         high while the add sequence is running
//   done         one-cycle completion pulse
//   result       registered product low word, held until the next completion
//   alu_dataA    ALU operand A (accumulator while running, else 0)
//   alu_dataB    ALU operand B (shifted multiplicand or 0)
//   alu_Signal   ALU function code, always ADD
//   alu_dataOut  combinational ALU sum, consumed in the cycle it is driven
module alu_mul_seq #(
  parameter int          EARLY_EXIT = 1,
  parameter logic [5:0]  ADD_CODE   = 6'b100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_Signal,
  input  logic [31:0] alu_dataOut
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] acc;
  logic [4:0]  cnt;
  logic        last_step;

  // The current step is the last one when all 32 steps are spent, or (with
  // early exit) when no multiplier bits remain above the one being consumed.
  always_comb begin
    last_step = (cnt == 5'd31);
    if ((EARLY_EXIT != 0) && (mplier[31:1] == 31'd0))
      last_step = 1'b1;
  end

  // ALU drive: accumulate while running, park at 0 + 0 otherwise.
  always_comb begin
    busy       = (state == S_RUN);
    done       = (state == S_DONE);
    alu_Signal = ADD_CODE;
    alu_dataA  = 32'd0;
    alu_dataB  = 32'd0;
    if (state == S_RUN) begin
      alu_dataA = acc;
      alu_dataB = mplier[0] ? mcand : 32'd0;
    end
  end

  // Sequencer state: ALU sum registered back into the accumulator each step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= 32'd0;
      mplier <= 32'd0;
      acc    <= 32'd0;
      cnt    <= 5'd0;
      result <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= 32'd0;
            cnt    <= 5'd0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          acc    <= alu_dataOut;
          mcand  <= {mcand[30:0], 1'b0};
          mplier <= {1'b0, mplier[31:1]};
          cnt    <= cnt + 5'd1;
          if (last_step) begin
            result <= alu_dataOut;
            state  <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq: one instance with early exit, one without,
// each paired with a behavioural ALU that only adds when given the ADD code.
module tb_alu_mul_seq;

  localparam logic [5:0] ADD = 6'b100000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start1 = 1'b0, start0 = 1'b0;
  logic [31:0] op_a = 32'd0, op_b = 32'd0;

  logic        busy1, done1, busy0, done0;
  logic [31:0] result1, a1, b1, out1, result0, a0, b0, out0;
  logic [5:0]  sig1, sig0;

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign out1 = (sig1 == ADD) ? a1 + b1 : 32'hDEAD_BEEF;
  assign out0 = (sig0 == ADD) ? a0 + b0 : 32'hDEAD_BEEF;

  alu_mul_seq #(.EARLY_EXIT(1), .ADD_CODE(ADD)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op_a(op_a), .op_b(op_b),
    .busy(busy1), .done(done1), .result(result1),
    .alu_dataA(a1), .alu_dataB(b1), .alu_Signal(sig1), .alu_dataOut(out1));

  alu_mul_seq #(.EARLY_EXIT(0), .ADD_CODE(ADD)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .op_a(op_a), .op_b(op_b),
    .busy(busy0), .done(done0), .result(result0),
    .alu_dataA(a0), .alu_dataB(b0), .alu_Signal(sig0), .alu_dataOut(out0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input bit sel, input string tag);
    chk({tag, " alu_dataA"},  sel ? a1 : a0, 32'd0);
    chk({tag, " alu_dataB"},  sel ? b1 : b0, 32'd0);
    chk({tag, " alu_Signal"}, {26'd0, sel ? sig1 : sig0}, {26'd0, ADD});
  endtask

  // Starts a multiply in the current cycle (cycle 0) and checks every cycle up
  // to N+2. inj>0 pulses a 5x5 start in that RUN cycle; abort>0 drops rst_n in
  // that cycle and checks the aborted state instead of completion.
  task automatic run_mul(input bit sel, input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] res, input int inj,
                         input int abort);
    logic [63:0] mask;
    logic [31:0] mp, exp_acc, exp_b;
    op_a = a; op_b = b;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start0 = 1'b0;
    for (int c = 1; c <= n + 2; c++) begin
      if (inj != 0 && c == inj) begin
        op_a = 32'd5; op_b = 32'd5;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      if (inj != 0 && c == inj + 1) begin
        start1 = 1'b0; start0 = 1'b0;
      end
      @(negedge clk);
      if (c <= n) begin
        chk($sformatf("busy c%0d", c), {31'd0, sel ? busy1 : busy0}, 32'd1);
        chk($sformatf("done c%0d", c), {31'd0, sel ? done1 : done0}, 32'd0);
        mask    = (64'd1 << (c - 1)) - 64'd1;
        exp_acc = a * b[31:0] & 32'hFFFF_FFFF;
        exp_acc = a * (b & mask[31:0]);
        mp      = b >> (c - 1);
        exp_b   = mp[0] ? (a << (c - 1)) : 32'd0;
        chk($sformatf("alu_dataA c%0d", c), sel ? a1 : a0, exp_acc);
        chk($sformatf("alu_dataB c%0d", c), sel ? b1 : b0, exp_b);
        chk($sformatf("alu_Signal c%0d", c), {26'd0, sel ? sig1 : sig0}, {26'd0, ADD});
      end else if (c == n + 1) begin
        chk("busy in done", {31'd0, sel ? busy1 : busy0}, 32'd0);
        chk("done pulse",   {31'd0, sel ? done1 : done0}, 32'd1);
        chk("result",       sel ? result1 : result0, res);
        chk_idle_outputs(sel, "done cycle");
      end else begin
        chk("busy after", {31'd0, sel ? busy1 : busy0}, 32'd0);
        chk("done after", {31'd0, sel ? done1 : done0}, 32'd0);
        chk("result held", sel ? result1 : result0, res);
        chk_idle_outputs(sel, "after done");
      end
      if (abort != 0 && c == abort) begin
        rst_n = 1'b0;
        #1;
        chk("abort busy",   {31'd0, sel ? busy1 : busy0}, 32'd0);
        chk("abort done",   {31'd0, sel ? done1 : done0}, 32'd0);
        chk("abort result", sel ? result1 : result0, 32'd0);
        chk_idle_outputs(sel, "abort");
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("no done after abort", {31'd0, sel ? done1 : done0}, 32'd0);
          chk("no busy after abort", {31'd0, sel ? busy1 : busy0}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle after abort", {31'd0, sel ? busy1 : busy0}, 32'd0);
        chk("result after abort", sel ? result1 : result0, 32'd0);
        return;
      end
      if (c < n + 2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("reset busy1",   {31'd0, busy1}, 32'd0);
    chk("reset done1",   {31'd0, done1}, 32'd0);
    chk("reset result1", result1, 32'd0);
    chk("reset result0", result0, 32'd0);
    chk("reset busy0",   {31'd0, busy0}, 32'd0);
    chk_idle_outputs(1'b1, "reset dut1");
    chk_idle_outputs(1'b0, "reset dut0");
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Early exit instance
    run_mul(1'b1, 32'd7,          32'd6,          3,  32'h0000_002A, 0, 0);
    run_mul(1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32, 32'h0000_0001, 0, 0);
    run_mul(1'b1, 32'hFFFF_FFFD,  32'd5,          3,  32'hFFFF_FFF1, 0, 0);
    run_mul(1'b1, 32'h0000_1234,  32'd0,          1,  32'h0000_0000, 0, 0);

    // Fixed 32-step instance
    run_mul(1'b0, 32'd7,          32'd6,          32, 32'h0000_002A, 0, 0);

    // Ignored start during RUN, then back-to-back start in cycle N+2
    run_mul(1'b1, 32'd3,          32'h8000_0000,  32, 32'h8000_0000, 10, 0);
    run_mul(1'b1, 32'd2,          32'd2,          2,  32'h0000_0004, 0, 0);

    // Reset mid-run, then a clean rerun
    run_mul(1'b1, 32'd9,          32'd9,          4,  32'h0000_0051, 0, 2);
    @(posedge clk); #1;
    run_mul(1'b1, 32'd9,          32'd9,          4,  32'h0000_0051, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
